// File: rtl/ppu_pkg.sv
// Shared timing constants, VRAM map bases and arbiter state type for the PPU scan controller.
package ppu_pkg;

  localparam int VRAM_AW = 13;

  localparam logic [7:0] H_ACTIVE = 8'd160;
  localparam logic [7:0] H_TOTAL  = 8'd228;
  localparam logic [7:0] V_ACTIVE = 8'd144;
  localparam logic [7:0] V_TOTAL  = 8'd154;
  localparam logic [7:0] H_LAST   = H_TOTAL - 8'd1;
  localparam logic [7:0] V_LAST   = V_TOTAL - 8'd1;
  localparam int         PIPE_LAT = 3;

  localparam logic [VRAM_AW-1:0] TILE_SET_BASE  = 13'h0000;
  localparam logic [VRAM_AW-1:0] SPRITES_BASE   = 13'h1300;
  localparam logic [VRAM_AW-1:0] PAL_SET_BASE   = 13'h1400;
  localparam logic [VRAM_AW-1:0] PAL_MAP_BASE   = 13'h1600;
  localparam logic [VRAM_AW-1:0] TILE_MAP0_BASE = 13'h1800;
  localparam logic [VRAM_AW-1:0] TILE_MAP1_BASE = 13'h1C00;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  function automatic logic in_active(input logic [7:0] h, input logic [7:0] v);
    return (h < H_ACTIVE) && (v < V_ACTIVE);
  endfunction

  // Whether the raster position k cycles ahead of (h,v) lies in the visible region.
  function automatic logic active_ahead(input logic [7:0] h, input logic [7:0] v,
                                        input logic [1:0] k);
    logic [7:0] ha;
    logic [7:0] va;
    ha = h + {6'd0, k};
    va = v;
    if (ha >= H_TOTAL) begin
      ha = ha - H_TOTAL;
      va = (v == V_LAST) ? 8'd0 : v + 8'd1;
    end
    return in_active(ha, va);
  endfunction

endpackage

// File: rtl/ppu_scan_ctrl_if.sv
// CPU-side VRAM request bus: request held with address/data until the one-cycle ack.
interface ppu_scan_ctrl_if;

  logic                        cpu_req;
  logic                        cpu_we;
  logic [ppu_pkg::VRAM_AW-1:0] cpu_addr;
  logic [7:0]                  cpu_wdata;
  logic                        cpu_ack;
  logic [7:0]                  cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );

endinterface

// File: rtl/ppu_raster_timer.sv
// Raster position counters, blanking flags and the fetch-pipeline occupancy shift register.
module ppu_raster_timer
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] h_cnt,
  output logic [7:0] v_cnt,
  output logic       active,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start,
  output logic       pix_valid,
  output logic       pipe_busy
);

  logic [PIPE_LAT-1:0] act_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt  <= 8'd0;
      v_cnt  <= 8'd0;
      act_sr <= '0;
    end else begin
      act_sr <= {act_sr[PIPE_LAT-2:0], active};
      if (h_cnt == H_LAST) begin
        h_cnt <= 8'd0;
        v_cnt <= (v_cnt == V_LAST) ? 8'd0 : v_cnt + 8'd1;
      end else begin
        h_cnt <= h_cnt + 8'd1;
      end
    end
  end

  // frame_start is held low while reset is asserted even though the counters sit at the origin.
  always_comb begin
    active      = in_active(h_cnt, v_cnt);
    hblank      = (h_cnt >= H_ACTIVE);
    vblank      = (v_cnt >= V_ACTIVE);
    frame_start = !rst && (h_cnt == 8'd0) && (v_cnt == 8'd0);
    pix_valid   = act_sr[PIPE_LAT-1];
    pipe_busy   = |act_sr;
  end

endmodule

// File: rtl/ppu_scan_ctrl.sv
// PPU raster sequencer and VRAM arbiter; CPU gets the VRAM port only in blanking with the pipe drained.
// Optional sticky vblank interrupt when PPU_VBLANK_IRQ_EN is defined.
module ppu_scan_ctrl
  import ppu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ppu_scan_ctrl_if.slave     cpu,
  input  logic [7:0]         scroll_x_in,
  input  logic [7:0]         scroll_y_in,
  output logic [7:0]         x_view,
  output logic [7:0]         y_view,
  output logic [7:0]         x_offset,
  output logic [7:0]         y_offset,
  output logic               hblank,
  output logic               vblank,
  output logic               pix_valid,
  output logic               frame_start,
  output logic               vram_owner,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata
`ifdef PPU_VBLANK_IRQ_EN
  ,
  output logic               vblank_irq,
  input  logic               irq_clr
`endif
);

  logic [7:0] h_cnt;
  logic [7:0] v_cnt;
  logic       active;
  logic       pipe_busy;
  logic       grant_ok;
  logic       frame_last;
  arb_state_t state;
  logic       ack_q;
  logic       rd_q;
  logic [7:0] rdata_q;

  ppu_raster_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hblank      (hblank),
    .vblank      (vblank),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pipe_busy   (pipe_busy)
  );

  // The grant window must also cover the ACCESS and DONE cycles that follow, hence the lookahead.
  always_comb begin
    x_view     = active ? h_cnt : 8'd0;
    y_view     = v_cnt;
    frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    grant_ok   = !active && !pipe_busy &&
                 !active_ahead(h_cnt, v_cnt, 2'd1) &&
                 !active_ahead(h_cnt, v_cnt, 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_offset <= 8'd0;
      y_offset <= 8'd0;
    end else if (frame_last) begin
      x_offset <= scroll_x_in;
      y_offset <= scroll_y_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vram_owner <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'd0;
      ack_q      <= 1'b0;
      rd_q       <= 1'b0;
      rdata_q    <= 8'd0;
    end else begin
      vram_owner <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'd0;
      ack_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.cpu_req && grant_ok) begin
            state      <= ACCESS;
            vram_owner <= 1'b1;
            vram_we    <= cpu.cpu_we;
            vram_addr  <= cpu.cpu_addr;
            vram_wdata <= cpu.cpu_wdata;
            rd_q       <= !cpu.cpu_we;
          end
        end
        ACCESS: begin
          state <= DONE;
          ack_q <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          if (rd_q) rdata_q <= vram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // VRAM returns read data during DONE, so the ack cycle forwards it directly and rdata_q holds it after.
  assign cpu.cpu_ack   = ack_q;
  assign cpu.cpu_rdata = (ack_q && rd_q) ? vram_rdata : rdata_q;

`ifdef PPU_VBLANK_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_irq <= 1'b0;
    end else if ((h_cnt == 8'd0) && (v_cnt == V_ACTIVE)) begin
      vblank_irq <= 1'b1;
    end else if (irq_clr) begin
      vblank_irq <= 1'b0;
    end
  end
`endif

  owner_outside_active: assert property (@(posedge clk) disable iff (rst)
    vram_owner |-> !(active || pipe_busy));

endmodule

// File: tb/tb_ppu_scan_ctrl.sv
// Scoreboard bench for ppu_scan_ctrl: directed CPU accesses at raster boundaries, raster model per cycle.
module tb_ppu_scan_ctrl;
  import ppu_pkg::*;

  localparam int HT    = 228;
  localparam int VT    = 154;
  localparam int FRAME = HT * VT;

  typedef struct {
    int          at_cyc;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  typedef struct {
    int         at_cyc;
    logic [7:0] rdata;
  } ack_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  scroll_x_in, scroll_y_in;
  logic [7:0]  x_view, y_view, x_offset, y_offset;
  logic        hblank, vblank, pix_valid, frame_start;
  logic        vram_owner, vram_we;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;
`ifdef PPU_VBLANK_IRQ_EN
  logic        vblank_irq;
  logic        irq_clr;
`endif

  logic [7:0]  mem [0:8191];
  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  acc_t        acc_q[$];
  ack_t        ack_q[$];

  ppu_scan_ctrl_if bus ();

  ppu_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (bus),
    .scroll_x_in (scroll_x_in),
    .scroll_y_in (scroll_y_in),
    .x_view      (x_view),
    .y_view      (y_view),
    .x_offset    (x_offset),
    .y_offset    (y_offset),
    .hblank      (hblank),
    .vblank      (vblank),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .vram_owner  (vram_owner),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_wdata  (vram_wdata),
    .vram_rdata  (vram_rdata)
`ifdef PPU_VBLANK_IRQ_EN
    ,
    .vblank_irq  (vblank_irq),
    .irq_clr     (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // VRAM model: registered read one cycle after the address, preloaded while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      mem[13'h1300] <= 8'h96;
      mem[13'h0123] <= 8'h3C;
    end else if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
    end
    vram_rdata <= mem[vram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int at(input int h, input int v);
    return v * HT + h;
  endfunction

  function automatic logic m_active(input int c);
    int h, v;
    if (c < 0) return 1'b0;
    h = c % HT;
    v = (c / HT) % VT;
    return (h < 160) && (v < 144);
  endfunction

  // Monitor: raster model every cycle, grant and ack events popped from the scoreboard queues.
  always @(negedge clk) begin : monitor
    int         h, v;
    logic [19:0] exp_r;
    acc_t       ea;
    ack_t       ek;
    if (!rst) begin
      h = cyc % HT;
      v = (cyc / HT) % VT;
      exp_r = {(h == 0 && v == 0), (h >= 160), (v >= 144), m_active(cyc - 3),
               m_active(cyc) ? 8'(h) : 8'd0, 8'(v)};
      checkOutput("raster", {frame_start, hblank, vblank, pix_valid, x_view, y_view}, {12'd0, exp_r});
      if (vram_owner) begin
        checkOutput("owner_in_active",
                    m_active(cyc) || m_active(cyc - 1) || m_active(cyc - 2) || m_active(cyc - 3), 0);
        if (acc_q.size() > 0) begin
          ea = acc_q.pop_front();
          checkOutput("grant_cycle", cyc, ea.at_cyc);
          checkOutput("grant_bus", {vram_we, vram_addr}, {ea.we, ea.addr});
          if (ea.we) checkOutput("grant_wdata", vram_wdata, ea.wdata);
        end else begin
          checkOutput("grant_expected", vram_owner, 0);
        end
      end else begin
        checkOutput("idle_bus", {vram_we, vram_addr}, 0);
      end
      if (bus.cpu_ack) begin
        if (ack_q.size() > 0) begin
          ek = ack_q.pop_front();
          checkOutput("ack_cycle", cyc, ek.at_cyc);
          checkOutput("ack_rdata", bus.cpu_rdata, ek.rdata);
        end else begin
          checkOutput("ack_expected", bus.cpu_ack, 0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc != target && guard < 100000) begin
      tick();
      guard++;
    end
    if (cyc != target) checkOutput("wait_cyc", cyc, target);
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cpu_ack && n < 40000);
    if (!bus.cpu_ack) checkOutput("ack_timeout", bus.cpu_ack, 1);
  endtask

  task automatic applyStimulus(input logic we, input logic [12:0] addr, input logic [7:0] wdata,
                               input int acc_cyc, input logic want_ack, input logic [7:0] rdata);
    acc_t ea;
    ack_t ek;
    ea.at_cyc = acc_cyc;
    ea.we     = we;
    ea.addr   = addr;
    ea.wdata  = wdata;
    acc_q.push_back(ea);
    if (want_ack) begin
      ek.at_cyc = acc_cyc + 1;
      ek.rdata  = rdata;
      ack_q.push_back(ek);
    end
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_req   = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    scroll_x_in   = 8'h11;
    scroll_y_in   = 8'h22;
`ifdef PPU_VBLANK_IRQ_EN
    irq_clr       = 1'b0;
`endif
    repeat (3) tick();
    checkOutput("rst_raster", {frame_start, hblank, vblank, pix_valid, x_view, y_view}, 0);
    checkOutput("rst_offsets", {x_offset, y_offset}, 0);
    checkOutput("rst_cpu", {bus.cpu_ack, bus.cpu_rdata}, 0);
    checkOutput("rst_vram", {vram_owner, vram_we, vram_addr, vram_wdata}, 0);
    rst = 1'b0;

    wait_cyc(at(0, 1));
    checkOutput("line_after_228", y_view, 1);

    // Last grantable slot before an active line: ACCESS/DONE still fit in this line's hblank.
    wait_cyc(at(225, 4));
    applyStimulus(1'b0, 13'h1300, 8'h00, at(226, 4), 1'b1, 8'h96);
    wait_ack();
    bus.cpu_req = 1'b0;

    wait_cyc(at(10, 5));
    applyStimulus(1'b0, 13'h0123, 8'h00, at(164, 5), 1'b1, 8'h3C);
    wait_ack();
    bus.cpu_req = 1'b0;

    wait_cyc(at(226, 5));
    applyStimulus(1'b1, 13'h1C05, 8'h77, at(164, 6), 1'b1, 8'h3C);
    wait_ack();
    bus.cpu_req = 1'b0;

    wait_cyc(at(0, 50));
    scroll_x_in = 8'h20;
    wait_cyc(at(0, 100));
    checkOutput("offset_mid_frame", {x_offset, y_offset}, 16'h0000);

`ifdef PPU_VBLANK_IRQ_EN
    wait_cyc(at(0, 144));
    checkOutput("irq_before_set", vblank_irq, 0);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    checkOutput("irq_set_wins", vblank_irq, 1);
    wait_cyc(at(5, 144));
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    checkOutput("irq_cleared", vblank_irq, 0);
`endif

    wait_cyc(at(20, 150));
    applyStimulus(1'b1, 13'h1800, 8'hA5, at(21, 150), 1'b1, 8'h3C);
    wait_ack();
    applyStimulus(1'b0, 13'h1800, 8'h00, at(24, 150), 1'b1, 8'hA5);
    wait_ack();
    applyStimulus(1'b0, 13'h1C05, 8'h00, at(27, 150), 1'b1, 8'h77);
    wait_ack();
    bus.cpu_req = 1'b0;

    wait_cyc(at(226, 153));
    applyStimulus(1'b0, 13'h1300, 8'h00, FRAME + at(164, 0), 1'b1, 8'h96);
    wait_cyc(at(227, 153));
    checkOutput("offset_frame_end", {x_offset, y_offset}, 16'h0000);
    wait_cyc(FRAME);
    checkOutput("offset_new_frame", {x_offset, y_offset}, 16'h2022);
    checkOutput("frame_start_repeat", frame_start, 1);
    wait_ack();
    bus.cpu_req = 1'b0;

    wait_cyc(FRAME + at(10, 150));
    applyStimulus(1'b1, 13'h1800, 8'h5A, FRAME + at(11, 150), 1'b0, 8'h00);
    tick();
    checkOutput("owner_before_reset", vram_owner, 1);
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    tick();
    tick();
    checkOutput("reset_mid_access", {bus.cpu_ack, vram_owner, vram_we}, 0);
    rst = 1'b0;
    repeat (20) tick();
    checkOutput("no_ack_after_reset", bus.cpu_ack, 0);

    checkOutput("ack_q_drained", ack_q.size(), 0);
    checkOutput("acc_q_drained", acc_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
